// File: rtl/timekeeper_ctrl_if.sv
// Signal bundle between the wall-clock controller and its surroundings.
// The board switches come in as plain levels. The time fields, LED image
// and pulse/status flags go out, along with a debug copy of the mode state.
//
// Signalling: there is no valid/ready handshake on this bundle.
//  - clock_on, hour_set, minute_set and time_set are levels. They are
//    sampled on every rising clk edge.
//  - seconds, minutes, hours, leds and set_err are registered levels.
//  - sec_tick and day_tick are single-cycle registered pulses.
//  - state_dbg encodes the mode as 0=PAUSE, 1=RUN, 2=SET_H, 3=SET_M.
interface timekeeper_ctrl_if;
    logic        clock_on;
    logic        hour_set;
    logic        minute_set;
    logic [5:0]  time_set;
    logic [5:0]  seconds;
    logic [5:0]  minutes;
    logic [4:0]  hours;
    logic [16:0] leds;
    logic        sec_tick;
    logic        day_tick;
    logic        set_err;
    logic [1:0]  state_dbg;

    // Switch side: drives the controls and observes the time.
    modport master (
        output clock_on, hour_set, minute_set, time_set,
        input  seconds, minutes, hours, leds, sec_tick, day_tick, set_err,
               state_dbg
    );

    // Controller side.
    modport slave (
        input  clock_on, hour_set, minute_set, time_set,
        output seconds, minutes, hours, leds, sec_tick, day_tick, set_err,
               state_dbg
    );
endinterface

// File: rtl/timekeeper_ctrl.sv
// Wall-clock controller.
// It divides clk down to a once-per-second enable, then advances
// seconds/minutes/hours with carry. It also owns the hour/minute set modes.
// Everything runs on clk alone. The mode register and every counter update
// are registered, so a switch change takes two cycles to reach the outputs.
module timekeeper_ctrl #(
    parameter int TICKS_PER_SEC = 32768,
    parameter int PRESCALE_W    = 15
) (
    input  logic             clk,
    input  logic             rstn,
    timekeeper_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_PAUSE = 2'd0,
        ST_RUN   = 2'd1,
        ST_SET_H = 2'd2,
        ST_SET_M = 2'd3
    } state_t;

    localparam logic [PRESCALE_W-1:0] PRESC_MAX  = PRESCALE_W'(TICKS_PER_SEC - 1);
    localparam logic [PRESCALE_W-1:0] PRESC_ZERO = '0;
    localparam logic [PRESCALE_W-1:0] PRESC_ONE  = PRESCALE_W'(1);

    state_t                state_q, state_d;
    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic [5:0]            sec_q, sec_d;
    logic [5:0]            min_q, min_d;
    logic [4:0]            hr_q, hr_d;
    logic                  sec_tick_q, sec_tick_d;
    logic                  day_tick_q, day_tick_d;
    logic                  set_err_q, set_err_d;

    // Mode register. Reset parks the clock in PAUSE.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_PAUSE;
        end else begin
            state_q <= state_d;
        end
    end

    // Mode selection is re-evaluated every cycle. Set switches win over
    // run/pause, and hour_set wins over minute_set.
    always_comb begin
        state_d = ST_PAUSE;
        if (bus.hour_set) begin
            state_d = ST_SET_H;
        end else if (bus.minute_set) begin
            state_d = ST_SET_M;
        end else if (bus.clock_on) begin
            state_d = ST_RUN;
        end
    end

    // Next counter values, computed from the registered mode.
    // Pulses and set_err default low, so they last for exactly one cycle
    // unless this cycle raises them again.
    always_comb begin
        presc_d    = presc_q;
        sec_d      = sec_q;
        min_d      = min_q;
        hr_d       = hr_q;
        sec_tick_d = 1'b0;
        day_tick_d = 1'b0;
        set_err_d  = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (presc_q == PRESC_MAX) begin
                    presc_d    = PRESC_ZERO;
                    sec_tick_d = 1'b1;
                    if (sec_q == 6'd59) begin
                        sec_d = 6'd0;
                        if (min_q == 6'd59) begin
                            min_d = 6'd0;
                            if (hr_q == 5'd23) begin
                                hr_d       = 5'd0;
                                day_tick_d = 1'b1;
                            end else begin
                                hr_d = hr_q + 5'd1;
                            end
                        end else begin
                            min_d = min_q + 6'd1;
                        end
                    end else begin
                        sec_d = sec_q + 6'd1;
                    end
                end else begin
                    presc_d = presc_q + PRESC_ONE;
                end
            end
            ST_SET_H: begin
                // Zero the sub-second phase so that a return to RUN starts a full second.
                presc_d = PRESC_ZERO;
                sec_d   = 6'd0;
                // The compare uses all six bits, so 32..63 cannot alias to a small hour.
                if (bus.time_set < 6'd24) begin
                    hr_d = bus.time_set[4:0];
                end else begin
                    set_err_d = 1'b1;
                end
            end
            ST_SET_M: begin
                presc_d = PRESC_ZERO;
                sec_d   = 6'd0;
                if (bus.time_set < 6'd60) begin
                    min_d = bus.time_set;
                end else begin
                    set_err_d = 1'b1;
                end
            end
            default: begin
                // PAUSE: everything holds and no ticks are generated.
            end
        endcase
    end

    // Datapath registers. Reset clears the time and all flags.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            presc_q    <= PRESC_ZERO;
            sec_q      <= 6'd0;
            min_q      <= 6'd0;
            hr_q       <= 5'd0;
            sec_tick_q <= 1'b0;
            day_tick_q <= 1'b0;
            set_err_q  <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            sec_q      <= sec_d;
            min_q      <= min_d;
            hr_q       <= hr_d;
            sec_tick_q <= sec_tick_d;
            day_tick_q <= day_tick_d;
            set_err_q  <= set_err_d;
        end
    end

    assign bus.seconds   = sec_q;
    assign bus.minutes   = min_q;
    assign bus.hours     = hr_q;
    assign bus.leds      = {hr_q, min_q, sec_q};
    assign bus.sec_tick  = sec_tick_q;
    assign bus.day_tick  = day_tick_q;
    assign bus.set_err   = set_err_q;
    assign bus.state_dbg = state_q;

endmodule
